// File: rtl/dd_fill_engine.sv
// dd_fill_engine: drives a constant, incrementing or alternating fill pattern onto the DD bus
// as per-bit out/enable pairs for a programmed number of sequencer-paced write slots.
module dd_fill_engine #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 12
) (
  input  logic               MasterClock,
  input  logic               RESETL,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   patA,
  input  logic [WIDTH-1:0]   patB,
  input  logic [WIDTH-1:0]   mask,
  input  logic [COUNT_W-1:0] length,
  input  logic               step,
  input  logic               abort,
  output logic [WIDTH-1:0]   outDD,
  output logic [WIDTH-1:0]   enDD,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] offset
);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} stateT;
  stateT state, nextState;
  logic [1:0]         modeQ;
  logic [WIDTH-1:0]   patAQ, patBQ, maskQ, data;
  logic [COUNT_W-1:0] remaining;
  logic               onB, accept;
  // abort beats a same-edge step, so the word is neither counted nor advanced
  assign accept = (state == DRIVE) && step && !abort;
  always_ff @(posedge MasterClock)
    state <= !RESETL ? IDLE : nextState;
  always_comb
    nextState = state == IDLE  ? (start ? (length != '0 ? DRIVE : DONE) : IDLE) :
                state == DRIVE ? (abort ? IDLE : (accept && remaining == COUNT_W'(1)) ? DONE : DRIVE) :
                IDLE;
  always_ff @(posedge MasterClock) begin
    if (!RESETL) begin
      modeQ     <= '0;
      patAQ     <= '0;
      patBQ     <= '0;
      maskQ     <= '0;
      data      <= '0;
      remaining <= '0;
      offset    <= '0;
      onB       <= 1'b0;
    end else if (state == IDLE && start) begin
      modeQ     <= mode;
      patAQ     <= patA;
      patBQ     <= patB;
      maskQ     <= mask;
      data      <= patA;
      remaining <= length;
      offset    <= '0;
      onB       <= 1'b0;
    end else if (accept) begin
      remaining <= remaining - COUNT_W'(1);
      offset    <= offset + COUNT_W'(1);
      data      <= modeQ == 2'd1 ? data + WIDTH'(1) :
                   modeQ == 2'd2 ? (onB ? patAQ : patBQ) : data;
      onB       <= !onB;
    end
  end
  always_comb begin
    busy  = state == DRIVE;
    done  = state == DONE;
    enDD  = busy ? maskQ : '0;
    outDD = data & enDD;
  end
endmodule

// File: tb/tb_dd_fill_engine.sv
// tb_dd_fill_engine: directed test-plan fills plus randomized fills, each cycle's outputs
// predicted by a fill-level model into a queue that a posedge monitor drains.
module tb_dd_fill_engine;
  localparam int W = 16;
  localparam int C = 12;
  logic MasterClock = 0, RESETL = 0, start = 0, step = 0, abort = 0;
  logic [1:0] mode = 0;
  logic [W-1:0] patA = 0, patB = 0, mask = 0, outDD, enDD;
  logic [C-1:0] length = 0, offset;
  logic busy, done;
  dd_fill_engine #(.WIDTH(W), .COUNT_W(C)) dut (
    .MasterClock(MasterClock), .RESETL(RESETL), .start(start), .mode(mode), .patA(patA),
    .patB(patB), .mask(mask), .length(length), .step(step), .abort(abort), .outDD(outDD),
    .enDD(enDD), .busy(busy), .done(done), .offset(offset)
  );
  always #5 MasterClock = ~MasterClock;
  typedef struct packed {
    logic [W-1:0] out;
    logic [W-1:0] en;
    logic         busy;
    logic         done;
    logic [C-1:0] off;
  } expT;
  expT q[$];
  int passed = 0, total = 0, cyc = 0;
  bit running = 1;
  bit mActive = 0, mDone = 0;
  int mK = 0, mLen = 0;
  logic [1:0] mMode = 0;
  logic [W-1:0] mA = 0, mB = 0, mMask = 0;
  logic [C-1:0] mOff = 0;
  function automatic logic [W-1:0] wordAt(int k);
    if (mMode == 2'd1) return mA + W'(k);
    if (mMode == 2'd2) return (k % 2 == 1) ? mB : mA;
    return mA;
  endfunction
  // advance the fill model across the coming edge and queue the outputs it implies
  task automatic tick();
    expT e;
    if (!RESETL) begin
      mActive = 0; mDone = 0; mOff = 0;
    end else if (mDone) begin
      mDone = 0;
    end else if (mActive) begin
      if (abort) mActive = 0;
      else if (step) begin
        mK++;
        mOff = C'(mK);
        if (mK == mLen) begin mActive = 0; mDone = 1; end
      end
    end else if (start) begin
      mOff = 0;
      if (length == 0) mDone = 1;
      else begin
        mActive = 1; mK = 0; mLen = int'(length);
        mMode = mode; mA = patA; mB = patB; mMask = mask;
      end
    end
    e.en   = mActive ? mMask : '0;
    e.out  = mActive ? (wordAt(mK) & mMask) : '0;
    e.busy = mActive;
    e.done = mDone;
    e.off  = mOff;
    q.push_back(e);
    @(negedge MasterClock);
  endtask
  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s cycle %0d: got %h expected %h", n, cyc, got, exp);
  endtask
  always @(posedge MasterClock) begin : monitor
    expT e;
    #1;
    if (running) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL queue cycle %0d: got no expectation expected one", cyc);
      end else begin
        e = q.pop_front();
        chk("outDD", 32'(outDD), 32'(e.out));
        chk("enDD", 32'(enDD), 32'(e.en));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("offset", 32'(offset), 32'(e.off));
      end
      cyc++;
    end
  end
  task automatic scramble();
    mode = 2'($urandom); patA = W'($urandom); patB = W'($urandom);
    mask = W'($urandom); length = C'($urandom);
  endtask
  task automatic startFill(logic [1:0] m, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] mk,
                           logic [C-1:0] len);
    mode = m; patA = a; patB = b; mask = mk; length = len; start = 1;
    tick();
    start = 0;
    scramble();
  endtask
  task automatic run(int n, int sm);
    for (int i = 0; i < n; i++) begin
      step = sm == 1 ? 1'b1 : sm == 2 ? (i % 2 == 1) : sm == 3 ? 1'($urandom) : 1'b0;
      tick();
    end
    step = 0;
  endtask
  initial begin
    tick(); tick();
    RESETL = 1;
    tick();
    startFill(2'd0, 16'hA5C3, 16'h0000, 16'h00FF, 12'd4); run(7, 1);
    startFill(2'd1, 16'hFFFE, 16'h0000, 16'hFFFF, 12'd3); run(8, 2); run(2, 0);
    startFill(2'd2, 16'h1111, 16'h2222, 16'hFFFF, 12'd5); run(10, 0);
    start = 1; length = 12'd1; tick(); start = 0;
    run(8, 1);
    startFill(2'd3, 16'h5A5A, 16'h0000, 16'hFFFF, 12'd6); run(2, 1);
    step = 1; abort = 1; tick(); step = 0; abort = 0;
    run(3, 0);
    startFill(2'd1, 16'h1234, 16'h0000, 16'hFFFF, 12'd0); run(3, 0);
    startFill(2'd1, 16'h0100, 16'h0000, 16'h0F0F, 12'd8); run(3, 1);
    RESETL = 0; tick(); RESETL = 1;
    run(2, 0);
    startFill(2'd2, 16'hAAAA, 16'h5555, 16'hFFFF, 12'd2); run(4, 1);
    abort = 1; step = 1; tick(); tick(); abort = 0; step = 0;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(0, 12);
      startFill(2'($urandom), W'($urandom), W'($urandom), W'($urandom), C'(len));
      for (int j = 0; j < 3 * len + 3; j++) begin
        step  = 1'($urandom);
        abort = $urandom_range(0, 24) == 0;
        start = $urandom_range(0, 5) == 0;
        scramble();
        tick();
      end
      step = 0; abort = 0; start = 0;
      run(2, 0);
    end
    running = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
